// File: rtl/usb_in_ep_scheduler.sv
// usb_in_ep_scheduler: round-robin packetizer sharing one
// USB IN endpoint between two first-word-fall-through byte FIFOs.
module usb_in_ep_scheduler #(
   parameter int MAX_PKT  = 64,
   parameter int FLUSH_TO = 16,
   parameter bit ZLP_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] src0_dout,
   input  logic       src0_empty,
   output logic       src0_pop,
   input  logic [7:0] src1_dout,
   input  logic       src1_empty,
   output logic       src1_pop,
   output logic       in_ep_req,
   input  logic       in_ep_grant,
   input  logic       in_ep_data_free,
   output logic       in_ep_data_put,
   output logic [7:0] in_ep_data,
   output logic       in_ep_data_done,
   input  logic       in_ep_acked,
   output logic       active_src,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      XFER,
      DONE,
      WAIT_ACK
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        sel;
   logic        rr_ptr;
   logic        put_q;
   logic        ack_q;
   logic [1:0]  zlp_pend;
   logic [7:0]  cnt;
   logic [15:0] idle;
   logic        cand0;
   logic        cand1;
   logic        pick;
   logic        sel_empty;
   logic        full;
   logic        flush;
   logic        zlp_go;

   assign cand0     = !src0_empty | zlp_pend[0];
   assign cand1     = !src1_empty | zlp_pend[1];
   assign pick      = (cand0 & cand1) ? rr_ptr : cand1;
   assign sel_empty = sel ? src1_empty : src0_empty;
   assign full      = (cnt == 8'(MAX_PKT));
   assign flush     = (idle == 16'(FLUSH_TO - 1));
   // A ZLP entry is the only way to reach XFER with nothing queued.
   assign zlp_go    = sel_empty & (cnt == 8'd0) & zlp_pend[sel];

   // put_q spaces puts so the FIFO head settles after every pop
   assign in_ep_data_put = (state == XFER) & in_ep_grant &
                           in_ep_data_free & !sel_empty &
                           !put_q & !full;
   assign src0_pop   = in_ep_data_put & !sel;
   assign src1_pop   = in_ep_data_put & sel;
   assign busy       = (state != IDLE);
   assign active_src = sel;
   assign in_ep_data = !busy ? 8'd0 :
                       (sel ? src1_dout : src0_dout);

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_nx        = state;
      in_ep_req       = 1'b0;
      in_ep_data_done = 1'b0;
      case (state)
         IDLE: begin
            if (cand0 | cand1) state_nx = REQ;
         end
         REQ: begin
            in_ep_req = 1'b1;
            if (in_ep_grant) state_nx = XFER;
         end
         XFER: begin
            in_ep_req = 1'b1;
            if (in_ep_grant & (full | flush | zlp_go))
               state_nx = DONE;
         end
         DONE: begin
            in_ep_req       = 1'b1;
            in_ep_data_done = 1'b1;
            state_nx        = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (in_ep_acked | ack_q) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Source select, packet counters and ZLP/ack bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel      <= 1'b0;
         rr_ptr   <= 1'b0;
         put_q    <= 1'b0;
         ack_q    <= 1'b0;
         zlp_pend <= 2'b00;
         cnt      <= 8'd0;
         idle     <= 16'd0;
      end else begin
         put_q <= in_ep_data_put;
         if (state == IDLE && (cand0 | cand1)) begin
            sel <= pick;
         end
         if (state == REQ && in_ep_grant) begin
            cnt  <= 8'd0;
            idle <= 16'd0;
         end
         if (state == XFER && in_ep_grant) begin
            if (in_ep_data_put) cnt <= cnt + 8'd1;
            idle <= sel_empty ? idle + 16'd1 : 16'd0;
         end
         if (state == DONE) begin
            zlp_pend[sel] <= ZLP_EN & full;
            ack_q         <= in_ep_acked;
         end
         if (state == WAIT_ACK && (in_ep_acked | ack_q)) begin
            rr_ptr <= ~sel;
            ack_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_usb_in_ep_scheduler.sv
// tb_usb_in_ep_scheduler: randomized bench with FIFO models
// and a packet-level reference model of the scheduler.
module tb_usb_in_ep_scheduler;

   localparam int MAX_PKT  = 64;
   localparam int FLUSH_TO = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] src0_dout, src1_dout, in_ep_data;
   logic       src0_empty, src1_empty, src0_pop, src1_pop;
   logic       in_ep_req, in_ep_grant, in_ep_data_free;
   logic       in_ep_data_put, in_ep_data_done, in_ep_acked;
   logic       active_src, busy;

   int pass_cnt = 0;
   int total = 0;

   byte unsigned q0[$], q1[$];
   int obs_src[$], obs_len[$], exp_src[$], exp_len[$];
   bit grant_rand;
   bit ack_hold;
   int pause_at, pause_len;
   int last_put_cyc, last_gap;

   always #5 clk = ~clk;

   usb_in_ep_scheduler #(
      .MAX_PKT (MAX_PKT),
      .FLUSH_TO(FLUSH_TO),
      .ZLP_EN  (1'b1)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .src0_dout      (src0_dout),
      .src0_empty     (src0_empty),
      .src0_pop       (src0_pop),
      .src1_dout      (src1_dout),
      .src1_empty     (src1_empty),
      .src1_pop       (src1_pop),
      .in_ep_req      (in_ep_req),
      .in_ep_grant    (in_ep_grant),
      .in_ep_data_free(in_ep_data_free),
      .in_ep_data_put (in_ep_data_put),
      .in_ep_data     (in_ep_data),
      .in_ep_data_done(in_ep_data_done),
      .in_ep_acked    (in_ep_acked),
      .active_src     (active_src),
      .busy           (busy)
   );

   task automatic drive_fifos();
      src0_empty = (q0.size() == 0);
      src1_empty = (q1.size() == 0);
      src0_dout  = src0_empty ? 8'($urandom) : q0[0];
      src1_dout  = src1_empty ? 8'($urandom) : q1[0];
   endtask

   task automatic do_reset();
      reset_n         = 1'b0;
      in_ep_grant     = 1'b1;
      in_ep_data_free = 1'b1;
      in_ep_acked     = 1'b0;
      grant_rand      = 1'b0;
      ack_hold        = 1'b0;
      pause_at        = -1;
      pause_len       = 0;
      q0.delete();
      q1.delete();
      obs_src.delete();
      obs_len.delete();
      drive_fifos();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic load(input int n0, input int n1);
      for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
   endtask

   // Packet list the spec's rules produce for preloaded FIFOs.
   task automatic build_model(input int n0, input int n1);
      int rem[2];
      bit zp[2];
      int rr, pick, len;
      bit c0, c1;
      rem[0] = n0;
      rem[1] = n1;
      zp[0] = 1'b0;
      zp[1] = 1'b0;
      rr = 0;
      exp_src.delete();
      exp_len.delete();
      for (int k = 0; k < 64; k++) begin
         c0 = (rem[0] > 0) || zp[0];
         c1 = (rem[1] > 0) || zp[1];
         if (!c0 && !c1) break;
         pick = (c0 && c1) ? rr : (c0 ? 0 : 1);
         len = (rem[pick] < MAX_PKT) ? rem[pick] : MAX_PKT;
         rem[pick] -= len;
         zp[pick] = (len == MAX_PKT);
         exp_src.push_back(pick);
         exp_len.push_back(len);
         rr = 1 - pick;
      end
   endtask

   // Cycle engine: FIFO/endpoint models plus per-cycle invariants.
   task automatic run(input int budget, input int stop_puts);
      int quiet, pkt_puts, ack_wait, pause_left, puts_total;
      bit pop0_p, pop1_p, prev_done, stopped, sel_emp;
      logic [7:0] head;
      quiet = 0; pkt_puts = 0; ack_wait = -1; pause_left = 0;
      puts_total = 0; pop0_p = 0; pop1_p = 0; prev_done = 0;
      stopped = 0;
      for (int cyc = 0; cyc < budget && quiet < 8 && !stopped;
           cyc++) begin
         @(posedge clk);
         #1;
         if (pop0_p) void'(q0.pop_front());
         if (pop1_p) void'(q1.pop_front());
         in_ep_acked = ack_hold || (ack_wait == 0);
         if (ack_wait >= 0) ack_wait--;
         if (pause_left > 0) pause_left--;
         in_ep_data_free = (pause_left == 0);
         in_ep_grant = grant_rand ? ($urandom_range(0, 5) != 0)
                                  : 1'b1;
         drive_fifos();
         #1;
         pop0_p = src0_pop;
         pop1_p = src1_pop;
         if (in_ep_data_put) begin
            sel_emp = active_src ? src1_empty : src0_empty;
            head = active_src ? src1_dout : src0_dout;
            total++;
            if (!(in_ep_grant && in_ep_data_free))
               $display("FAIL put_gate: put=1 grant=%0b free=%0b",
                        in_ep_grant, in_ep_data_free);
            else pass_cnt++;
            total++;
            if (sel_emp)
               $display("FAIL put_empty: put on empty src%0d",
                        active_src);
            else if (in_ep_data !== head)
               $display("FAIL data: got %02h want %02h",
                        in_ep_data, head);
            else pass_cnt++;
            total++;
            if ({src1_pop, src0_pop} !==
                (active_src ? 2'b10 : 2'b01))
               $display("FAIL pop_sel: pops=%b src=%0d",
                        {src1_pop, src0_pop}, active_src);
            else pass_cnt++;
            pkt_puts++;
            puts_total++;
            last_put_cyc = cyc;
            if (puts_total == pause_at) pause_left = pause_len + 1;
            if (puts_total == stop_puts) stopped = 1;
         end else if (src0_pop || src1_pop) begin
            total++;
            $display("FAIL pop_no_put: pops=%b",
                     {src1_pop, src0_pop});
         end
         if (in_ep_data_done) begin
            total++;
            if (prev_done || pkt_puts > MAX_PKT)
               $display("FAIL done: len=%0d repeat=%0b",
                        pkt_puts, prev_done);
            else pass_cnt++;
            obs_src.push_back(int'(active_src));
            obs_len.push_back(pkt_puts);
            last_gap = cyc - last_put_cyc;
            pkt_puts = 0;
            ack_wait = $urandom_range(0, 3);
         end
         prev_done = in_ep_data_done;
         if (!busy && q0.size() == 0 && q1.size() == 0) quiet++;
         else quiet = 0;
      end
      if (!stopped) begin
         total++;
         if (quiet < 8)
            $display("FAIL timeout: quiet=%0d budget=%0d",
                     quiet, budget);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      q0.delete();
      q1.delete();
      drive_fifos();
      in_ep_grant = 1'b1;
      in_ep_data_free = 1'b1;
      in_ep_acked = 1'b0;
      #1;
      total++;
      if ({src0_pop, src1_pop, in_ep_req, in_ep_data_put,
           in_ep_data, in_ep_data_done, active_src, busy} !== 15'd0)
         $display("FAIL reset_outs: req=%b put=%b done=%b busy=%b",
                  in_ep_req, in_ep_data_put, in_ep_data_done, busy);
      else pass_cnt++;
      do_reset();
      run(40, -1);
      total++;
      if (obs_len.size() !== 0 || in_ep_req !== 1'b0)
         $display("FAIL reset_idle: pkts=%0d req=%b",
                  obs_len.size(), in_ep_req);
      else pass_cnt++;
   endtask

   task automatic test_short_flush();
      do_reset();
      load(10, 0);
      build_model(10, 0);
      run(400, -1);
      total++;
      if (obs_len.size() !== exp_len.size())
         $display("FAIL flush_cnt: got %0d want %0d",
                  obs_len.size(), exp_len.size());
      else pass_cnt++;
      for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
         total++;
         if (obs_len[i] !== exp_len[i] || obs_src[i] !== exp_src[i])
            $display("FAIL flush_pkt%0d: got %0d/%0d want %0d/%0d", i,
                     obs_src[i], obs_len[i], exp_src[i], exp_len[i]);
         else pass_cnt++;
      end
      total++;
      if (last_gap < FLUSH_TO || last_gap > FLUSH_TO + 2)
         $display("FAIL flush_gap: got %0d want %0d..%0d",
                  last_gap, FLUSH_TO, FLUSH_TO + 2);
      else pass_cnt++;
   endtask

   task automatic test_pkts(input string nm, input int n0,
                            input int n1, input bit hold);
      do_reset();
      ack_hold = hold;
      load(n0, n1);
      build_model(n0, n1);
      run(3000, -1);
      total++;
      if (obs_len.size() !== exp_len.size())
         $display("FAIL %s_cnt: got %0d want %0d", nm,
                  obs_len.size(), exp_len.size());
      else pass_cnt++;
      for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
         total++;
         if (obs_len[i] !== exp_len[i] || obs_src[i] !== exp_src[i])
            $display("FAIL %s_pkt%0d: got %0d/%0d want %0d/%0d", nm, i,
                     obs_src[i], obs_len[i], exp_src[i], exp_len[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_free_pause();
      do_reset();
      pause_at = 15;
      pause_len = 5;
      load(0, 40);
      build_model(0, 40);
      run(1000, -1);
      total++;
      if (obs_len.size() !== 1 || obs_len[0] !== exp_len[0] ||
          obs_src[0] !== exp_src[0])
         $display("FAIL pause_pkt: pkts=%0d want 1 of %0d",
                  obs_len.size(), exp_len[0]);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int n0, n1;
      for (int r = 0; r < 4; r++) begin
         do_reset();
         grant_rand = 1'b1;
         ack_hold = 1'($urandom_range(0, 1));
         n0 = $urandom_range(0, 150);
         n1 = $urandom_range(0, 150);
         load(n0, n1);
         build_model(n0, n1);
         run(6000, -1);
         total++;
         if (obs_len.size() !== exp_len.size())
            $display("FAIL rand%0d_cnt: got %0d want %0d (n0=%0d n1=%0d)",
                     r, obs_len.size(), exp_len.size(), n0, n1);
         else pass_cnt++;
         for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
            total++;
            if (obs_len[i] !== exp_len[i] || obs_src[i] !== exp_src[i])
               $display("FAIL rand%0d_pkt%0d: got %0d/%0d want %0d/%0d",
                        r, i, obs_src[i], obs_len[i],
                        exp_src[i], exp_len[i]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      load(64, 30);
      run(2000, 84);
      total++;
      if (obs_len.size() !== 1 || in_ep_data_put !== 1'b1)
         $display("FAIL rmid_pre: pkts=%0d put=%b",
                  obs_len.size(), in_ep_data_put);
      else pass_cnt++;
      reset_n = 1'b0;
      #1;
      total++;
      if ({src0_pop, src1_pop, in_ep_req, in_ep_data_put,
           in_ep_data, in_ep_data_done, active_src, busy} !== 15'd0)
         $display("FAIL rmid_outs: req=%b put=%b done=%b busy=%b",
                  in_ep_req, in_ep_data_put, in_ep_data_done, busy);
      else pass_cnt++;
      q0.delete();
      q1.delete();
      obs_len.delete();
      obs_src.delete();
      drive_fifos();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      run(60, -1);
      total++;
      if (obs_len.size() !== 0 || busy !== 1'b0)
         $display("FAIL rmid_after: pkts=%0d busy=%b",
                  obs_len.size(), busy);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_short_flush();
      test_pkts("zlp", 64, 0, 1'b0);
      test_pkts("multi", 130, 0, 1'b0);
      test_pkts("b2b", 100, 100, 1'b1);
      test_free_pause();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
